vending_machine_multi: RTL and testbench
========================================

Name: vending_machine_multi

Overview:
Parametrised successor to the single-item vending FSM. Accepts the same 5/10 rupee coin encoding, accumulates credit up to a cap, and sells one of NUM_ITEMS items at per-item prices. Dispense and change-return use valid/ack handshakes toward the dispenser and coin-return mechanics. Sits between the coin acceptor/keypad front end and the dispenser driver; state_led feeds the panel LEDs.

Parameters:
NUM_ITEMS, 4, number of selectable items (1..8)
CREDIT_W, 6, width of credit, price and change values (rupees)
MAX_CREDIT, 50, credit cap in rupees; must be < 2**CREDIT_W
PRICE_LIST, {6'd25,6'd20,6'd15,6'd10}, packed prices; item i at [i*CREDIT_W +: CREDIT_W] (item0=10, item1=15, item2=20, item3=25); each price must be >0 and <=MAX_CREDIT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
coin_in  in  2  00 none, 01 = 5 rs, 10 = 10 rs, 11 = invalid coin; sampled every cycle
item_sel  in  3  item index; only low $clog2(NUM_ITEMS) bits used, values >= NUM_ITEMS invalid
buy  in  1  purchase request, single-cycle pulse
cancel  in  1  abort and refund, single-cycle pulse
vend_ack  in  1  dispenser has taken the item
change_ack  in  1  coin-return has paid out change
vend_valid  out  1  item ready to dispense; held until vend_ack
vend_item  out  3  latched item index, valid while vend_valid
change_valid  out  1  change pending; held until change_ack
change_amt  out  CREDIT_W  refund amount, valid while change_valid
credit  out  CREDIT_W  current credit
reject  out  1  one-cycle pulse: coin returned (invalid, overflow, or wrong state)
deny  out  1  one-cycle pulse: buy refused (bad index or insufficient credit)
state_led  out  3  IDLE 001, COLLECT 010, VEND 100, CHANGE 110

Behaviour:
- Reset (rst low, async): state IDLE, credit 0, all pulses/valids 0, vend_item 0, change_amt 0, state_led 001. Reset mid-transaction discards credit; no refund.
- All outputs registered; every effect is visible one cycle after the sampling edge.
- IDLE (credit==0) / COLLECT (credit>0): valid coin adds 5/10 to credit. If the sum would exceed MAX_CREDIT, the coin is rejected and credit is unchanged. Coin 11 always gives reject and leaves credit unchanged. The first accepted coin moves IDLE->COLLECT.
- buy in COLLECT, evaluated against the pre-edge credit:
  - bad index or credit < price: deny pulse, no state change.
  - otherwise: credit -= price, vend_item latched, go to VEND.
  - buy in IDLE: deny.
- Priority when inputs coincide: cancel > buy > coin. A coin arriving in the same cycle as an accepted cancel or buy is rejected. A coin arriving with a denied buy is accepted normally.
- cancel in COLLECT: change_amt = credit, go to CHANGE. cancel in IDLE: ignored. cancel in VEND/CHANGE: ignored.
- VEND: vend_valid=1 until vend_ack is seen high at an edge. Then go to CHANGE if credit>0 (change_amt=credit), else IDLE. vend_valid drops the cycle after ack.
- CHANGE: change_valid=1 until change_ack. Then credit=0, go to IDLE.
- Any coin in VEND/CHANGE: reject pulse. buy in VEND/CHANGE: deny.
- Acks outside their own state are ignored.
- Width rule: credit arithmetic is done CREDIT_W+1 wide for the overflow check. Subtraction never underflows because of the price check.

Optional Feature:
MULTI_BUY_EN
- Defined: after vend_ack with remaining credit>0, go to COLLECT and keep the credit, so the customer can buy again. Change is paid only on cancel.
- Undefined: the remaining credit is refunded through CHANGE automatically, as specified above.

Decomposition:
- Package vm_pkg holds:
  - coin codes (COIN_NONE, COIN_5, COIN_10, COIN_BAD) and coin values (5, 10)
  - state enum (IDLE, COLLECT, VEND, CHANGE) and the LED encodings
- One sub-module, vm_credit_acc: owns the credit register, add with overflow check, subtract price, clear, and the reject-overflow flag.
- The FSM, price lookup and handshakes live in the top module.

Test Plan:
1. Reset low 2 cycles then high -> credit=0, state_led=001. Coins 01, 10, 11 on consecutive cycles -> credit 5, then 15; reject pulse on the 11 cycle; state_led=010.
2. Credit 15, item_sel=1, buy -> vend_valid=1, vend_item=1, credit=0. vend_ack -> IDLE, no change_valid.
3. Coins 10, 10 (credit 20), buy item0 -> VEND, credit 10. vend_ack -> change_valid, change_amt=10. change_ack -> IDLE, credit 0. With MULTI_BUY_EN: COLLECT instead, credit stays 10.
4. Credit 5, buy item3 -> deny, credit stays 5. item_sel=5, buy -> deny. Cancel -> change_amt=5.
5. Credit 45, coin 10 -> reject, credit 45. buy item0 with coin 01 in the same cycle -> vend, credit 35, reject for the coin.
6. rst low while in VEND with credit 10 -> immediately vend_valid=0, credit=0, state_led=001.

Source files
------------

// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_pkg
// Description : Shared coin codes, coin values, FSM state type and panel LED
//               encodings for the multi-item vending machine.
// Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

  // Coin acceptor codes
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Coin values in rupees
  localparam logic [3:0] COIN_VAL_5  = 4'd5;
  localparam logic [3:0] COIN_VAL_10 = 4'd10;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  // Panel LED encodings
  localparam logic [2:0] LED_IDLE    = 3'b001;
  localparam logic [2:0] LED_COLLECT = 3'b010;
  localparam logic [2:0] LED_VEND    = 3'b100;
  localparam logic [2:0] LED_CHANGE  = 3'b110;

  function automatic logic [2:0] state_led_f(input state_t s);
    case (s)
      IDLE:    state_led_f = LED_IDLE;
      COLLECT: state_led_f = LED_COLLECT;
      VEND:    state_led_f = LED_VEND;
      default: state_led_f = LED_CHANGE;
    endcase
  endfunction

  // Value of a coin code; the invalid code and "no coin" are worth nothing
  function automatic logic [3:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  coin_value = COIN_VAL_5;
      COIN_10: coin_value = COIN_VAL_10;
      default: coin_value = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm_credit_acc.sv
`default_nettype none
// ============================================================================
// Module      : vm_credit_acc
// Description : Credit accumulator. Adds coin values with a cap check done
//               one bit wider than the credit, subtracts item prices and
//               clears on payout. ovf flags a coin that would exceed the cap.
// Revision    : 1.0 - initial release
// ============================================================================
module vm_credit_acc #(
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                add_en,
  input  logic [CREDIT_W-1:0] add_val,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] sub_val,
  input  logic                clr,
  output logic [CREDIT_W-1:0] credit,
  output logic                ovf
);

  localparam logic [CREDIT_W:0] c_max_credit = (CREDIT_W+1)'(MAX_CREDIT);

  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W:0]   w_sum;

  assign w_sum  = {1'b0, r_credit} + {1'b0, add_val};
  assign ovf    = (w_sum > c_max_credit);
  assign credit = r_credit;

  // Credit register: clear beats subtract beats add; an overflowing add is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit <= '0;
    end else if (clr) begin
      r_credit <= '0;
    end else if (sub_en) begin
      r_credit <= r_credit - sub_val;
    end else if (add_en && !ovf) begin
      r_credit <= w_sum[CREDIT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine_multi
// Description : Multi-item vending controller. Collects 5/10 rupee coins up
//               to a cap, sells one of NUM_ITEMS items at per-item prices and
//               hands off to dispenser / coin-return via valid/ack.
//               Optional macro MULTI_BUY_EN: leftover credit after a vend
//               returns to COLLECT instead of being refunded automatically.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 6,
  parameter int                            MAX_CREDIT = 50,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {6'd25, 6'd20, 6'd15, 6'd10}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin_in,
  input  logic [2:0]          item_sel,
  input  logic                buy,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                change_ack,
  output logic                vend_valid,
  output logic [2:0]          vend_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject,
  output logic                deny,
  output logic [2:0]          state_led
);

  localparam logic [3:0] c_num_items = 4'(NUM_ITEMS);

  state_t              r_state, w_state_nx;
  logic                r_vend_valid, r_change_valid, r_reject, r_deny;
  logic [2:0]          r_vend_item, w_vend_item_nx;
  logic [CREDIT_W-1:0] r_change_amt, w_change_amt_nx;
  logic [2:0]          r_state_led;
  logic                w_reject_nx, w_deny_nx;

  logic                w_add_en, w_sub_en, w_clr, w_ovf;
  logic [CREDIT_W-1:0] w_credit, w_add_val, w_price;
  logic                w_coin_any, w_coin_ok, w_coin_take;
  logic                w_idx_ok, w_buy_ok;

  vm_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit_acc (
    .clk     (clk),
    .rst     (rst),
    .add_en  (w_add_en),
    .add_val (w_add_val),
    .sub_en  (w_sub_en),
    .sub_val (w_price),
    .clr     (w_clr),
    .credit  (w_credit),
    .ovf     (w_ovf)
  );

  assign w_coin_any = (coin_in != COIN_NONE);
  assign w_coin_ok  = w_coin_any && (coin_in != COIN_BAD);
  assign w_add_val  = CREDIT_W'(coin_value(coin_in));
  assign w_idx_ok   = ({1'b0, item_sel} < c_num_items);
  assign w_buy_ok   = w_idx_ok && (w_credit >= w_price);

  // Price lookup for the selected item; out-of-range indices read as zero
  always_comb begin
    w_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel == 3'(i)) w_price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
    end
  end

  // Next-state and next-output logic; priority cancel > buy > coin
  always_comb begin
    w_state_nx      = r_state;
    w_add_en        = 1'b0;
    w_sub_en        = 1'b0;
    w_clr           = 1'b0;
    w_reject_nx     = 1'b0;
    w_deny_nx       = 1'b0;
    w_coin_take     = 1'b0;
    w_vend_item_nx  = r_vend_item;
    w_change_amt_nx = r_change_amt;

    case (r_state)
      IDLE: begin
        w_deny_nx   = buy;
        w_coin_take = 1'b1;
      end
      COLLECT: begin
        if (cancel) begin
          w_change_amt_nx = w_credit;
          w_state_nx      = CHANGE;
          w_reject_nx     = w_coin_any;
        end else if (buy && w_buy_ok) begin
          w_sub_en       = 1'b1;
          w_vend_item_nx = item_sel;
          w_state_nx     = VEND;
          w_reject_nx    = w_coin_any;
        end else begin
          // A denied buy still lets a coin through
          w_deny_nx   = buy;
          w_coin_take = 1'b1;
        end
      end
      VEND: begin
        w_reject_nx = w_coin_any;
        w_deny_nx   = buy;
        if (vend_ack) begin
          if (w_credit != '0) begin
`ifdef MULTI_BUY_EN
            w_state_nx = COLLECT;
`else
            w_change_amt_nx = w_credit;
            w_state_nx      = CHANGE;
`endif
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: begin
        w_reject_nx = w_coin_any;
        w_deny_nx   = buy;
        if (change_ack) begin
          w_clr           = 1'b1;
          w_change_amt_nx = '0;
          w_state_nx      = IDLE;
        end
      end
    endcase

    // Coin acceptance in the collecting states
    if (w_coin_take && w_coin_any) begin
      if (w_coin_ok && !w_ovf) begin
        w_add_en = 1'b1;
        if (r_state == IDLE) w_state_nx = COLLECT;
      end else begin
        w_reject_nx = 1'b1;
      end
    end
  end

  // State and output registers; reset discards any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_vend_valid   <= 1'b0;
      r_change_valid <= 1'b0;
      r_reject       <= 1'b0;
      r_deny         <= 1'b0;
      r_vend_item    <= 3'd0;
      r_change_amt   <= '0;
      r_state_led    <= LED_IDLE;
    end else begin
      r_state        <= w_state_nx;
      r_vend_valid   <= (w_state_nx == VEND);
      r_change_valid <= (w_state_nx == CHANGE);
      r_reject       <= w_reject_nx;
      r_deny         <= w_deny_nx;
      r_vend_item    <= w_vend_item_nx;
      r_change_amt   <= w_change_amt_nx;
      r_state_led    <= state_led_f(w_state_nx);
    end
  end

  assign vend_valid   = r_vend_valid;
  assign vend_item    = r_vend_item;
  assign change_valid = r_change_valid;
  assign change_amt   = r_change_amt;
  assign credit       = w_credit;
  assign reject       = r_reject;
  assign deny         = r_deny;
  assign state_led    = r_state_led;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_machine_multi
// Description : Directed self-checking bench for vending_machine_multi with
//               hand-computed expectations (default prices 10/15/20/25,
//               cap 50). Honours MULTI_BUY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_in;
  logic [2:0] item_sel;
  logic       buy, cancel, vend_ack, change_ack;
  logic       vend_valid, change_valid, reject, deny;
  logic [2:0] vend_item, state_led;
  logic [5:0] change_amt, credit;

  int n_checks = 0;
  int n_fail   = 0;

  vending_machine_multi dut (
    .clk          (clk),
    .rst          (rst),
    .coin_in      (coin_in),
    .item_sel     (item_sel),
    .buy          (buy),
    .cancel       (cancel),
    .vend_ack     (vend_ack),
    .change_ack   (change_ack),
    .vend_valid   (vend_valid),
    .vend_item    (vend_item),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .credit       (credit),
    .reject       (reject),
    .deny         (deny),
    .state_led    (state_led)
  );

  always #5 clk = ~clk;

  // One clock: inputs set beforehand are sampled, then pulses return to idle
  task automatic cycle();
    @(posedge clk);
    #1;
    coin_in = 2'b00; buy = 1'b0; cancel = 1'b0; vend_ack = 1'b0; change_ack = 1'b0;
  endtask

  task automatic coin(input logic [1:0] c);
    coin_in = c;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; coin_in = 2'b00; item_sel = 3'd0;
    buy = 1'b0; cancel = 1'b0; vend_ack = 1'b0; change_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    n_checks++; if (state_led !== 3'b001) begin n_fail++; $display("FAIL reset_led: got %b expected 001", state_led); end
    n_checks++; if ({vend_valid, change_valid, reject, deny} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {vend_valid, change_valid, reject, deny}); end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_coins();
    coin(2'b01);
    n_checks++; if (credit !== 6'd5) begin n_fail++; $display("FAIL coin5_credit: got %0d expected 5", credit); end
    n_checks++; if (state_led !== 3'b010) begin n_fail++; $display("FAIL coin5_led: got %b expected 010", state_led); end
    coin(2'b10);
    n_checks++; if (credit !== 6'd15) begin n_fail++; $display("FAIL coin10_credit: got %0d expected 15", credit); end
    n_checks++; if (reject !== 1'b0) begin n_fail++; $display("FAIL coin10_reject: got %b expected 0", reject); end
    coin(2'b11);
    n_checks++; if (reject !== 1'b1) begin n_fail++; $display("FAIL badcoin_reject: got %b expected 1", reject); end
    n_checks++; if (credit !== 6'd15) begin n_fail++; $display("FAIL badcoin_credit: got %0d expected 15", credit); end
    cycle();
    n_checks++; if (reject !== 1'b0) begin n_fail++; $display("FAIL reject_pulse: got %b expected 0", reject); end
  endtask

  task automatic test_vend_exact();
    item_sel = 3'd1; buy = 1'b1;
    cycle();
    n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL exact_vend_valid: got %b expected 1", vend_valid); end
    n_checks++; if (vend_item !== 3'd1) begin n_fail++; $display("FAIL exact_vend_item: got %0d expected 1", vend_item); end
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL exact_credit: got %0d expected 0", credit); end
    n_checks++; if (state_led !== 3'b100) begin n_fail++; $display("FAIL exact_led: got %b expected 100", state_led); end
    change_ack = 1'b1;  // ack for the wrong state must be ignored
    cycle();
    n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL exact_hold: got %b expected 1", vend_valid); end
    vend_ack = 1'b1;
    cycle();
    n_checks++; if (vend_valid !== 1'b0) begin n_fail++; $display("FAIL exact_ack_drop: got %b expected 0", vend_valid); end
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL exact_no_change: got %b expected 0", change_valid); end
    n_checks++; if (state_led !== 3'b001) begin n_fail++; $display("FAIL exact_idle_led: got %b expected 001", state_led); end
  endtask

  task automatic test_vend_change();
    coin(2'b10);
    coin(2'b10);
    n_checks++; if (credit !== 6'd20) begin n_fail++; $display("FAIL chg_credit20: got %0d expected 20", credit); end
    item_sel = 3'd0; buy = 1'b1;
    cycle();
    n_checks++; if (credit !== 6'd10) begin n_fail++; $display("FAIL chg_after_buy: got %0d expected 10", credit); end
    n_checks++; if (vend_item !== 3'd0) begin n_fail++; $display("FAIL chg_vend_item: got %0d expected 0", vend_item); end
    vend_ack = 1'b1;
    cycle();
`ifdef MULTI_BUY_EN
    n_checks++; if (state_led !== 3'b010) begin n_fail++; $display("FAIL multi_led: got %b expected 010", state_led); end
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL multi_no_change: got %b expected 0", change_valid); end
    n_checks++; if (credit !== 6'd10) begin n_fail++; $display("FAIL multi_credit: got %0d expected 10", credit); end
    cancel = 1'b1;
    cycle();
`endif
    n_checks++; if (change_valid !== 1'b1) begin n_fail++; $display("FAIL chg_valid: got %b expected 1", change_valid); end
    n_checks++; if (change_amt !== 6'd10) begin n_fail++; $display("FAIL chg_amt: got %0d expected 10", change_amt); end
    n_checks++; if (state_led !== 3'b110) begin n_fail++; $display("FAIL chg_led: got %b expected 110", state_led); end
    change_ack = 1'b1;
    cycle();
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL chg_ack_drop: got %b expected 0", change_valid); end
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL chg_credit_clr: got %0d expected 0", credit); end
    n_checks++; if (state_led !== 3'b001) begin n_fail++; $display("FAIL chg_idle_led: got %b expected 001", state_led); end
  endtask

  task automatic test_deny();
    item_sel = 3'd0; buy = 1'b1;
    cycle();
    n_checks++; if (deny !== 1'b1) begin n_fail++; $display("FAIL idle_buy_deny: got %b expected 1", deny); end
    coin(2'b01);
    n_checks++; if (deny !== 1'b0) begin n_fail++; $display("FAIL deny_pulse: got %b expected 0", deny); end
    item_sel = 3'd3; buy = 1'b1;
    cycle();
    n_checks++; if (deny !== 1'b1) begin n_fail++; $display("FAIL poor_deny: got %b expected 1", deny); end
    n_checks++; if (credit !== 6'd5) begin n_fail++; $display("FAIL poor_credit: got %0d expected 5", credit); end
    n_checks++; if (state_led !== 3'b010) begin n_fail++; $display("FAIL poor_led: got %b expected 010", state_led); end
    item_sel = 3'd5; buy = 1'b1; coin_in = 2'b01;  // denied buy, coin still accepted
    cycle();
    n_checks++; if (deny !== 1'b1) begin n_fail++; $display("FAIL badidx_deny: got %b expected 1", deny); end
    n_checks++; if (credit !== 6'd10) begin n_fail++; $display("FAIL badidx_coin: got %0d expected 10", credit); end
    n_checks++; if (reject !== 1'b0) begin n_fail++; $display("FAIL badidx_reject: got %b expected 0", reject); end
    cancel = 1'b1; coin_in = 2'b10;  // coin with accepted cancel is rejected
    cycle();
    n_checks++; if (change_valid !== 1'b1) begin n_fail++; $display("FAIL cancel_valid: got %b expected 1", change_valid); end
    n_checks++; if (change_amt !== 6'd10) begin n_fail++; $display("FAIL cancel_amt: got %0d expected 10", change_amt); end
    n_checks++; if (reject !== 1'b1) begin n_fail++; $display("FAIL cancel_coin_reject: got %b expected 1", reject); end
    change_ack = 1'b1;
    cycle();
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL cancel_done: got %0d expected 0", credit); end
  endtask

  task automatic test_overflow();
    repeat (4) coin(2'b10);
    coin(2'b01);
    n_checks++; if (credit !== 6'd45) begin n_fail++; $display("FAIL fill45: got %0d expected 45", credit); end
    coin(2'b10);
    n_checks++; if (reject !== 1'b1) begin n_fail++; $display("FAIL ovf_reject: got %b expected 1", reject); end
    n_checks++; if (credit !== 6'd45) begin n_fail++; $display("FAIL ovf_credit: got %0d expected 45", credit); end
    item_sel = 3'd0; buy = 1'b1; coin_in = 2'b01;
    cycle();
    n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL buycoin_vend: got %b expected 1", vend_valid); end
    n_checks++; if (credit !== 6'd35) begin n_fail++; $display("FAIL buycoin_credit: got %0d expected 35", credit); end
    n_checks++; if (reject !== 1'b1) begin n_fail++; $display("FAIL buycoin_reject: got %b expected 1", reject); end
    vend_ack = 1'b1;
    cycle();
`ifdef MULTI_BUY_EN
    coin(2'b10);
    coin(2'b01);  // 35+10+5 lands exactly on the cap
    n_checks++; if (credit !== 6'd50) begin n_fail++; $display("FAIL cap50: got %0d expected 50", credit); end
    cancel = 1'b1;
    cycle();
    n_checks++; if (change_amt !== 6'd50) begin n_fail++; $display("FAIL cap50_refund: got %0d expected 50", change_amt); end
`else
    n_checks++; if (change_amt !== 6'd35) begin n_fail++; $display("FAIL auto_refund: got %0d expected 35", change_amt); end
`endif
    change_ack = 1'b1;
    cycle();
    n_checks++; if (state_led !== 3'b001) begin n_fail++; $display("FAIL ovf_idle: got %b expected 001", state_led); end
  endtask

  task automatic test_reset_mid();
    coin(2'b10);
    coin(2'b10);
    item_sel = 3'd0; buy = 1'b1;
    cycle();
    n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL mid_vend: got %b expected 1", vend_valid); end
    #3 rst = 1'b0;
    #1;
    n_checks++; if (vend_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", vend_valid); end
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL mid_rst_credit: got %0d expected 0", credit); end
    n_checks++; if (state_led !== 3'b001) begin n_fail++; $display("FAIL mid_rst_led: got %b expected 001", state_led); end
    #2 rst = 1'b1;
    cycle();
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_refund: got %b expected 0", change_valid); end
  endtask

  initial begin
    test_reset();
    test_coins();
    test_vend_exact();
    test_vend_change();
    test_deny();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
